ram_fifo_ctrl: RTL and testbench

- Control stage that sits directly upstream of the 16x8 dual-port RAM and drives both of its ports.
- Turns a push/pop stream interface into RAM write and read strobes and addresses, giving a synchronous FIFO.
- Keeps circular write/read pointers, occupancy count, status flags and sticky error flags.
- Clears the whole RAM once after every reset.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_ptr.sv | 26 ++
 rtl/ram_fifo_ctrl.sv | 159 +++++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller.
// Pointer flags are derived from the wrap-bit pointer pair.
package fifo_pkg;

   localparam int unsigned DataWDef = 8;
   localparam int unsigned AddrWDef = 4;

   typedef enum logic {
      StInit,
      StRun
   } state_e;

   typedef struct packed {
      logic full;
      logic empty;
   } ptr_flags_t;

   // Pointers are zero-extended to 32 bits; aw is the RAM address width.
   function automatic ptr_flags_t ptr_flags(input logic [31:0] wr, input logic [31:0] rd,
                                            input int unsigned aw);
      ptr_flags_t  f;
      logic [31:0] diff;
      logic [31:0] mask;
      diff    = wr ^ rd;
      mask    = (32'd1 << aw) - 32'd1;
      f.full  = ((diff & mask) == 32'd0) && diff[aw];
      f.empty = (diff == 32'd0);
      return f;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: a plain binary counter whose MSB toggles each time the
// lower address bits roll over.
module fifo_ptr #(
   parameter int unsigned Width = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [Width-1:0] ptr_o
);

   logic [Width-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) ptr_d = ptr_q + Width'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Push/pop FIFO control stage driving both ports of an external dual-port RAM.
// Clears the RAM once after every reset before accepting traffic.
module ram_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = DataWDef,
   parameter int unsigned ADDR_W   = AddrWDef,
   parameter int unsigned AF_LEVEL = 12,
   parameter int unsigned AE_LEVEL = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              dout_valid_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic [ADDR_W:0]   count_o,
   output logic              init_done_o,
   output logic              overflow_o,
   output logic              underflow_o,
   input  logic              clr_err_i,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_wr_addr_o,
   output logic [DATA_W-1:0] ram_din_o,
   output logic              ram_re_o,
   output logic [ADDR_W-1:0] ram_re_addr_o,
   input  logic [DATA_W-1:0] ram_dout_i
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned PW    = ADDR_W + 1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [PW-1:0]       count_q, count_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                run, push_ok, pop_ok;
   ptr_flags_t          flags;

   assign flags   = ptr_flags(32'(wr_ptr), 32'(rd_ptr), ADDR_W);
   assign run     = (state_q == StRun);
   assign push_ok = run & push_i & ~flags.full;
   assign pop_ok  = run & pop_i & ~flags.empty;

   fifo_ptr #(
      .Width (PW)
   ) u_wr_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (push_ok),
      .ptr_o  (wr_ptr)
   );

   fifo_ptr #(
      .Width (PW)
   ) u_rd_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (pop_ok),
      .ptr_o  (rd_ptr)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StInit;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   // Next state
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      unique case (state_q)
         StInit: begin
            init_addr_d = init_addr_q + ADDR_W'(1);
            if (init_addr_q == ADDR_W'(DEPTH - 1)) state_d = StRun;
         end
         StRun:   state_d = StRun;
         default: state_d = StInit;
      endcase
   end

   // RAM port outputs; both strobes are forced low while reset is held.
   always_comb begin
      ram_we_o      = 1'b0;
      ram_wr_addr_o = wr_ptr[ADDR_W-1:0];
      ram_din_o     = din_i;
      ram_re_o      = 1'b0;
      ram_re_addr_o = rd_ptr[ADDR_W-1:0];
      unique case (state_q)
         StInit: begin
            ram_we_o      = rst_ni;
            ram_wr_addr_o = init_addr_q;
            ram_din_o     = '0;
         end
         StRun: begin
            ram_we_o = rst_ni & push_ok;
            ram_re_o = rst_ni & pop_ok;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
      dout_d       = pop_ok ? ram_dout_i : dout_q;
      dout_valid_d = pop_ok;
      // Set beats clear when both happen in the same cycle.
      overflow_d   = (run & push_i & flags.full) | (overflow_q & ~clr_err_i);
      underflow_d  = (run & pop_i & flags.empty) | (underflow_q & ~clr_err_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign dout_o         = dout_q;
   assign dout_valid_o   = dout_valid_q;
   assign full_o         = ~run | flags.full;
   assign empty_o        = flags.empty;
   assign count_o        = count_q;
   assign almost_full_o  = (32'(count_q) >= AF_LEVEL);
   assign almost_empty_o = (32'(count_q) <= AE_LEVEL);
   assign init_done_o    = run;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based FIFO model.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, push, pop, clr;
   logic [7:0] din;
   logic [7:0] dout, ram_din, ram_dout;
   logic       dout_valid, full, empty, afull, aempty, init_done, ovf, unf;
   logic       ram_we, ram_re;
   logic [3:0] ram_wr_addr, ram_re_addr;
   logic [4:0] count;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl dut (
      .clk_i          (clk),
      .rst_ni         (rst),
      .push_i         (push),
      .din_i          (din),
      .pop_i          (pop),
      .dout_o         (dout),
      .dout_valid_o   (dout_valid),
      .full_o         (full),
      .empty_o        (empty),
      .almost_full_o  (afull),
      .almost_empty_o (aempty),
      .count_o        (count),
      .init_done_o    (init_done),
      .overflow_o     (ovf),
      .underflow_o    (unf),
      .clr_err_i      (clr),
      .ram_we_o       (ram_we),
      .ram_wr_addr_o  (ram_wr_addr),
      .ram_din_o      (ram_din),
      .ram_re_o       (ram_re),
      .ram_re_addr_o  (ram_re_addr),
      .ram_dout_i     (ram_dout)
   );

   // External 16x8 RAM, asynchronous read
   logic [7:0] mem [16];
   always @(posedge clk) if (ram_we) mem[ram_wr_addr] <= ram_din;
   assign ram_dout = mem[ram_re_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: contents as a queue, plus running write/read totals.
   logic [7:0] q[$];
   int         m_init;
   logic [3:0] wr_tot, rd_tot;
   logic [7:0] m_dout;
   bit         m_dv, m_ovf, m_unf;

   always @(posedge clk) begin
      bit fe, ee, pok, qok;
      if (!rst) begin
         q.delete();
         m_init = 0; wr_tot = 0; rd_tot = 0;
         m_dout = 0; m_dv = 0; m_ovf = 0; m_unf = 0;
      end else if (m_init < 16) begin
         m_init++;
         m_dv = 0;
      end else begin
         fe  = (q.size() == 16);
         ee  = (q.size() == 0);
         pok = push && !fe;
         qok = pop && !ee;
         m_ovf = (push && fe) || (m_ovf && !clr);
         m_unf = (pop && ee) || (m_unf && !clr);
         m_dv  = qok;
         if (qok) begin
            m_dout = q.pop_front();
            rd_tot++;
         end
         if (pok) begin
            q.push_back(din);
            wr_tot++;
         end
      end
   end

   always @(negedge clk) begin
      int sz;
      bit in_init, fe, ee, pok, qok, we_e;
      if (chk_en) begin
         sz      = q.size();
         in_init = (m_init < 16);
         fe      = in_init || sz == 16;
         ee      = (sz == 0);
         pok     = !in_init && push && !fe;
         qok     = !in_init && pop && !ee;
         we_e    = rst && (in_init || pok);
         chk("count", 32'(count), 32'(sz));
         chk("full", 32'(full), 32'(fe));
         chk("empty", 32'(empty), 32'(ee));
         chk("almost_full", 32'(afull), 32'(sz >= 12));
         chk("almost_empty", 32'(aempty), 32'(sz <= 4));
         chk("init_done", 32'(init_done), 32'(!in_init));
         chk("overflow", 32'(ovf), 32'(m_ovf));
         chk("underflow", 32'(unf), 32'(m_unf));
         chk("dout_valid", 32'(dout_valid), 32'(m_dv));
         chk("dout", 32'(dout), 32'(m_dout));
         chk("ram_we", 32'(ram_we), 32'(we_e));
         if (we_e) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), in_init ? 32'(m_init) : 32'(wr_tot));
            chk("ram_din", 32'(ram_din), in_init ? 32'd0 : 32'(din));
         end
         chk("ram_re", 32'(ram_re), 32'(rst && qok));
         if (rst && qok) chk("ram_re_addr", 32'(ram_re_addr), 32'(rd_tot));
      end
   end

   task automatic set_in(input bit r, input bit p, input logic [7:0] d, input bit po,
                         input bit c);
      rst = r; push = p; din = d; pop = po; clr = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pp;
      set_in(0, 0, 8'h00, 0, 0);
      step();
      chk_en = 1;
      step();
      chk("rst count", 32'(count), 0);
      chk("rst full", 32'(full), 1);
      chk("rst empty", 32'(empty), 1);
      chk("rst almost_empty", 32'(aempty), 1);
      chk("rst almost_full", 32'(afull), 0);
      chk("rst init_done", 32'(init_done), 0);
      chk("rst ram_we", 32'(ram_we), 0);

      // Init sweep with push held high
      set_in(1, 1, 8'hEE, 0, 0);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (i < 16) begin
            chk("init ram_we", 32'(ram_we), 1);
            chk("init addr", 32'(ram_wr_addr), 32'(i));
            chk("init din", 32'(ram_din), 0);
            chk("init not done", 32'(init_done), 0);
         end else if (i == 16) begin
            chk("init_done rise", 32'(init_done), 1);
            chk("init count", 32'(count), 0);
            chk("init overflow", 32'(ovf), 0);
         end
         step();
      end
      set_in(1, 0, 8'h00, 1, 0);
      for (int i = 0; i < 4; i++) step();
      set_in(1, 0, 8'h00, 0, 0);
      #1 chk("drained empty", 32'(empty), 1);

      // Ordered fill
      for (int i = 0; i < 16; i++) begin
         set_in(1, 1, 8'hA0 + 8'(i), 0, 0);
         step();
      end
      set_in(1, 0, 8'h00, 0, 0);
      #1;
      chk("fill full", 32'(full), 1);
      chk("fill count", 32'(count), 16);
      chk("fill almost_full", 32'(afull), 1);

      // Overflow then clear
      set_in(1, 1, 8'h55, 0, 0);
      step();
      set_in(1, 0, 8'h00, 0, 0);
      chk("ovf count", 32'(count), 16);
      chk("ovf set", 32'(ovf), 1);
      set_in(1, 0, 8'h00, 0, 1);
      step();
      set_in(1, 0, 8'h00, 0, 0);
      chk("ovf cleared", 32'(ovf), 0);

      // Ordered drain
      for (int i = 0; i < 16; i++) begin
         set_in(1, 0, 8'h00, 1, 0);
         #1 chk("drain ram_re", 32'(ram_re), 1);
         step();
         chk("drain dv", 32'(dout_valid), 1);
         chk("drain dout", 32'(dout), 32'(8'hA0 + 8'(i)));
      end
      set_in(1, 0, 8'h00, 0, 0);
      #1 chk("drain empty", 32'(empty), 1);

      // Underflow
      set_in(1, 0, 8'h00, 1, 0);
      step();
      set_in(1, 0, 8'h00, 0, 1);
      chk("unf set", 32'(unf), 1);
      chk("unf no dv", 32'(dout_valid), 0);
      step();

      // Simultaneous push/pop at count 5 across the address wrap
      for (int i = 0; i < 5; i++) begin
         set_in(1, 1, 8'h10 + 8'(i), 0, 0);
         step();
      end
      for (int i = 0; i < 12; i++) begin
         set_in(1, 1, 8'h15 + 8'(i), 1, 0);
         step();
         chk("simul count", 32'(count), 5);
         chk("simul dout", 32'(dout), 32'(8'h10 + 8'(i)));
      end

      // Full with push and pop together
      for (int i = 0; i < 11; i++) begin
         set_in(1, 1, 8'h21 + 8'(i), 0, 0);
         step();
      end
      set_in(1, 1, 8'h77, 1, 0);
      step();
      set_in(1, 0, 8'h00, 0, 0);
      chk("fullpp count", 32'(count), 15);
      chk("fullpp ovf", 32'(ovf), 1);
      chk("fullpp dv", 32'(dout_valid), 1);
      chk("fullpp dout", 32'(dout), 32'h1C);

      // Mid-operation reset
      set_in(1, 0, 8'h00, 1, 0);
      for (int i = 0; i < 6; i++) step();
      set_in(1, 0, 8'h00, 0, 0);
      chk("pre-rst count", 32'(count), 9);
      set_in(0, 0, 8'h00, 0, 0);
      step();
      chk("mid-rst count", 32'(count), 0);
      chk("mid-rst empty", 32'(empty), 1);
      chk("mid-rst dv", 32'(dout_valid), 0);
      chk("mid-rst init_done", 32'(init_done), 0);
      set_in(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++) begin
         chk("reinit not done", 32'(init_done), 0);
         step();
      end
      chk("reinit done", 32'(init_done), 1);
      set_in(1, 1, 8'h99, 0, 0);
      step();
      set_in(1, 0, 8'h00, 1, 0);
      step();
      set_in(1, 0, 8'h00, 0, 0);
      chk("resume dout", 32'(dout), 32'h99);

      // Random traffic with shifting push/pop bias
      pp = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) pp = $urandom_range(15, 85);
         set_in($urandom_range(0, 299) != 0,
                $urandom_range(0, 99) < pp,
                8'($urandom),
                $urandom_range(0, 99) >= pp,
                $urandom_range(0, 19) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
